// File: rtl/prim_clock_div_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : prim_clock_div_prog_if
// Description : Divisor and step-down handshake bundle for prim_clock_div_prog.
// Revision    : 1.0 - initial release
// ============================================================================
interface prim_clock_div_prog_if #(
    parameter int DivWidth = 8
);
    // Names are from the divider's point of view.
    logic                div_req_i;
    logic [DivWidth-1:0] div_i;
    logic                div_ack_o;
    logic                div_err_o;
    logic [DivWidth-1:0] div_o;
    logic                step_down_req_i;
    logic                step_down_ack_o;

    modport master (
        output div_req_i, div_i, step_down_req_i,
        input  div_ack_o, div_err_o, div_o, step_down_ack_o
    );

    modport slave (
        input  div_req_i, div_i, step_down_req_i,
        output div_ack_o, div_err_o, div_o, step_down_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/prim_clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module      : prim_clock_div_prog
// Description : Runtime-programmable integer clock divider (N = 2..2^DivWidth-1)
//               with glitch-free divisor / step-down switching at period wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module prim_clock_div_prog #(
    parameter int          DivWidth     = 8,
    parameter int unsigned ResetDivisor = 2,
    parameter bit          ResetValue   = 1'b0
) (
    input  wire                  clk_i,
    input  wire                  rst_ni,
    input  wire                  test_en_i,
    prim_clock_div_prog_if.slave div_if,
    output logic                 boundary_o,
    output logic                 clk_o
);

    localparam logic [0:0]          ST_IDLE     = 1'b0;
    localparam logic [0:0]          ST_PEND     = 1'b1;
    localparam logic [DivWidth-1:0] c_reset_div = DivWidth'(ResetDivisor);
    localparam logic [DivWidth-1:0] c_one       = DivWidth'(1);
    localparam logic [DivWidth-1:0] c_two       = DivWidth'(2);

    logic [0:0]          state_q,    state_d;
    logic [DivWidth-1:0] cnt_q,      cnt_d;
    logic [DivWidth-1:0] div_q,      div_d;
    logic [DivWidth-1:0] pend_div_q, pend_div_d;
    logic                clk_q,      clk_d;
    logic                sd_q,       sd_d;
    logic                ack_q,      ack_d;
    logic                err_q,      err_d;

    logic [DivWidth-1:0] w_half;
    logic [DivWidth-1:0] w_eff;
    logic [DivWidth-1:0] w_hi;
    logic                w_boundary;

    // Effective divisor and phase split derive only from registered state,
    // so they can change solely on a wrap edge.
    always_comb begin
        w_half     = div_q >> 1;
        w_eff      = div_q;
        if (sd_q) begin
            w_eff = (w_half < c_two) ? c_two : w_half;
        end
        w_hi       = (w_eff >> 1) + {{(DivWidth-1){1'b0}}, w_eff[0]};
        w_boundary = (cnt_q == (w_eff - c_one));
    end

    always_comb begin
        cnt_d      = w_boundary ? '0 : cnt_q + c_one;
        clk_d      = (cnt_d < w_hi);
        sd_d       = w_boundary ? (div_if.step_down_req_i & ~test_en_i) : sd_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        state_d    = state_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (div_if.div_req_i) begin
                if (div_if.div_i >= c_two) begin
                    pend_div_d = div_if.div_i;
                    state_d    = ST_PEND;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            // New divisor lands with cnt_d = 0, i.e. on the clk_o rising edge.
            if (w_boundary) begin
                div_d   = pend_div_q;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= c_reset_div;
            pend_div_q <= c_reset_div;
            clk_q      <= ResetValue;
            sd_q       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            clk_q      <= clk_d;
            sd_q       <= sd_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign div_if.div_ack_o       = ack_q;
    assign div_if.div_err_o       = err_q;
    assign div_if.div_o           = div_q;
    assign div_if.step_down_ack_o = sd_q;
    assign boundary_o             = w_boundary;
    assign clk_o                  = clk_q;

endmodule
`default_nettype wire
